// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reserved control
// opcodes, FSM state encoding, default widths and instruction field layout.
package fetch_pkg;

  // Default geometry: 16-entry store of 12-bit words {opcode, operand_a, operand_b}
  localparam int PC_W_DEF   = 4;
  localparam int DATA_W_DEF = 4;
  localparam int INSTR_W    = 3 * DATA_W_DEF;

  // Field positions in units of DATA_W; the field's lsb is index * DATA_W
  localparam int FIELD_OPC = 2;
  localparam int FIELD_OPA = 1;
  localparam int FIELD_OPB = 0;

  // Control opcodes resolved inside fetch; execute never sees these values
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Low bit of a field inside an instruction word built from data_w-wide fields
  function automatic int field_lsb(input int field, input int data_w);
    return field * data_w;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Issue bus between the fetch stage (master) and the execute stage (slave).
// Carries the decoded fields, the address they came from and a valid/ready pair.
interface instruction_fetch_if #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
);

  logic [DATA_W-1:0] opcode;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [PC_W-1:0]   pc;
  logic              instr_valid;
  logic              instr_ready;

  // Fetch side: drives the instruction, observes acceptance
  modport master (
    output opcode,
    output operand_a,
    output operand_b,
    output pc,
    output instr_valid,
    input  instr_ready
  );

  // Execute side: consumes the instruction, drives acceptance
  modport slave (
    input  opcode,
    input  operand_a,
    input  operand_b,
    input  pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/program_rom.sv
// Program store: 2**ADDR_W words, one synchronous write port and one
// synchronous read port. The read register doubles as the instruction register.
module program_rom #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port
  // NOTE: the array and read register take no reset, so the program survives
  // a reset and the store maps onto plain RAM without per-bit clear logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the 4-bit processor. Walks the program store with
// a program counter, resolves JMP and HALT locally and hands every other word
// to execute over a valid/ready handshake.
// Optional build macro: FETCH_PREFETCH_EN -- on an accepted issue the next
// word is read in the same cycle so instructions can issue back to back.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_addr,
  input  logic [3*DATA_W-1:0]   prog_data,
  instruction_fetch_if.master   issue,
  output logic                  busy,
  output logic                  halted
);

  localparam int IW      = 3 * DATA_W;
  localparam int OPC_LSB = field_lsb(FIELD_OPC, DATA_W);
  localparam int OPA_LSB = field_lsb(FIELD_OPA, DATA_W);
  localparam int OPB_LSB = field_lsb(FIELD_OPB, DATA_W);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] HALT  = ST_HALT;

  logic [1:0]        state, state_nx;
  logic [PC_W-1:0]   pc_q, pc_nx, pc_inc;
  logic              ir_ok;        // instruction register holds a fetched word
  logic              rd_en;
  logic [PC_W-1:0]   rd_addr;
  logic              wr_en;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] ir_opc, ir_opa, ir_opb;
  logic              is_halt, is_jmp, is_ctrl;
  logic              accept;

  // Program writes are only honoured while the processor is stopped
  assign wr_en = prog_we && ((state == IDLE) || (state == HALT));

  program_rom #(
    .ADDR_W (PC_W),
    .WORD_W (IW)
  ) u_rom (
    .clk   (clk),
    .we    (wr_en),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ir)
  );

  // Instruction register field split and control-opcode decode
  assign ir_opc  = ir[OPC_LSB +: DATA_W];
  assign ir_opa  = ir[OPA_LSB +: DATA_W];
  assign ir_opb  = ir[OPB_LSB +: DATA_W];
  assign is_halt = ir_ok && (ir_opc == DATA_W'(OP_HALT));
  assign is_jmp  = ir_ok && (ir_opc == DATA_W'(OP_JMP));
  assign is_ctrl = is_halt || is_jmp;
  assign pc_inc  = pc_q + PC_W'(1);

  // Issue bus: valid is a pure decode of state and the registered opcode;
  // control words and never-fetched contents show as zero fields
  assign issue.instr_valid = (state == ISSUE) && !is_ctrl;
  assign issue.opcode      = (ir_ok && !is_ctrl) ? ir_opc : '0;
  assign issue.operand_a   = (ir_ok && !is_ctrl) ? ir_opa : '0;
  assign issue.operand_b   = (ir_ok && !is_ctrl) ? ir_opb : '0;
  assign issue.pc          = pc_q;
  assign accept            = issue.instr_valid && issue.instr_ready;

  assign busy   = (state == FETCH) || (state == ISSUE);
  assign halted = (state == HALT);

  // Next-state, next-pc and store read request
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    rd_en    = 1'b0;
    rd_addr  = pc_q;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nx = FETCH;
          pc_nx    = '0;
        end
      end
      FETCH: begin
        rd_en    = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        if (is_halt) begin
          state_nx = HALT;
        end else if (is_jmp) begin
          pc_nx    = PC_W'(ir_opb);
          state_nx = FETCH;
        end else if (accept) begin
          pc_nx = pc_inc;
`ifdef FETCH_PREFETCH_EN
          rd_en    = 1'b1;
          rd_addr  = pc_inc;
          state_nx = ISSUE;
`else
          state_nx = FETCH;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, program counter and instruction-register-valid flag
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
      ir_ok <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (rd_en) begin
        ir_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: in-order issue, stall
// hold, JMP resolution, pc wrap, reset mid-handshake, write protection and
// issue rate in both builds.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] issued[$];
  logic [7:0]  vbits;
  logic        saw_f;

  instruction_fetch_if #(.PC_W(4), .DATA_W(4)) issue_if ();

  instruction_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .issue     (issue_if),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {valid, opcode, operand_a, operand_b, pc}
  task automatic check_issue(input string tag, input logic [16:0] exp);
    check(tag, {15'd0, issue_if.instr_valid, issue_if.opcode, issue_if.operand_a,
                issue_if.operand_b, issue_if.pc}, {15'd0, exp});
  endtask

  task automatic write_word(input logic [3:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic record();
    if (issue_if.instr_valid && issue_if.instr_ready)
      issued.push_back({issue_if.opcode, issue_if.operand_a, issue_if.operand_b, issue_if.pc});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    issue_if.instr_ready = 1'b0;
    tick();
    tick();
    check_issue("reset_fields", 17'h0);
    check("reset_busy_halted", {busy, halted}, 2'b00);
    reset = 1'b0;
    tick();

    // Basic in-order issue then HALT
    write_word(4'd0, 12'h123);
    write_word(4'd1, 12'h245);
    write_word(4'd2, 12'hE00);
    issue_if.instr_ready = 1'b1;
    pulse_start();
    check("start_fetch", {busy, issue_if.instr_valid}, 2'b10);
    tick();
    check_issue("first_issue", {1'b1, 16'h1230});
    issued.delete();
    for (int i = 0; i < 8; i++) begin
      record();
      tick();
    end
    check("basic_count", issued.size(), 2);
    if (issued.size() == 2) begin
      check("basic_word0", issued[0], 16'h1230);
      check("basic_word1", issued[1], 16'h2451);
    end
    check("basic_halted", halted, 1'b1);
    check("basic_halt_pc", issue_if.pc, 4'd2);
    check("basic_no_valid", issue_if.instr_valid, 1'b0);

    // Stall: fields held while ready is low
    issue_if.instr_ready = 1'b0;
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_issue("stall_hold", {1'b1, 16'h1230});
      tick();
    end
    check_issue("stall_end", {1'b1, 16'h1230});
    issue_if.instr_ready = 1'b1;
    tick();
    check("accept_on_ready", issue_if.pc, 4'd1);
    repeat (8) tick();
    check("stall_halted", halted, 1'b1);

    // JMP resolved in fetch, opcode F never exposed
    write_word(4'd0, 12'hF03);
    write_word(4'd3, 12'h1AB);
    write_word(4'd4, 12'hE00);
    pulse_start();
    issued.delete();
    saw_f = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (issue_if.opcode == 4'hF) saw_f = 1'b1;
      record();
      tick();
    end
    check("jmp_count", issued.size(), 1);
    if (issued.size() >= 1) check("jmp_target_word", issued[0], 16'h1AB3);
    check("jmp_no_opcode_f", saw_f, 1'b0);
    check("jmp_halt_pc", {halted, issue_if.pc}, {1'b1, 4'd4});

    // pc wraps from 15 to 0
    for (int i = 0; i < 16; i++) begin
      automatic logic [3:0] a = 4'(i);
      write_word(a, {a & 4'h7, a, ~a});
    end
    pulse_start();
    issued.delete();
    for (int cyc = 0; cyc < 80 && issued.size() < 17; cyc++) begin
      record();
      tick();
    end
    check("wrap_count", issued.size(), 17);
    if (issued.size() == 17) begin
      check("wrap_first", issued[0], 16'h00F0);
      check("wrap_pc15", issued[15], 16'h7F0F);
      check("wrap_to_0", issued[16], 16'h00F0);
    end

    // Reset during a pending handshake
    issue_if.instr_ready = 1'b0;
    for (int i = 0; i < 4 && !issue_if.instr_valid; i++) tick();
    check("pre_reset_valid", issue_if.instr_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_async_valid", issue_if.instr_valid, 1'b0);
    check("reset_async_pc", issue_if.pc, 4'd0);
    check("reset_async_idle", {busy, halted}, 2'b00);
    #1;
    reset = 1'b0;

    // Writes during ISSUE are dropped
    pulse_start();
    tick();
    check_issue("prot_issue", {1'b1, 16'h00F0});
    write_word(4'd0, 12'h777);
    check_issue("prot_held", {1'b1, 16'h00F0});
    reset = 1'b1;
    #1;
    reset = 1'b0;
    pulse_start();
    tick();
    check_issue("prot_readback", {1'b1, 16'h00F0});

    // Issue rate: three words then HALT
    reset = 1'b1;
    #1;
    reset = 1'b0;
    write_word(4'd0, 12'h111);
    write_word(4'd1, 12'h222);
    write_word(4'd2, 12'h333);
    write_word(4'd3, 12'hE00);
    issue_if.instr_ready = 1'b1;
    pulse_start();
    tick();
    vbits = '0;
    for (int i = 0; i < 8; i++) begin
      vbits[i] = issue_if.instr_valid;
      tick();
    end
`ifdef FETCH_PREFETCH_EN
    check("rate_pattern", vbits, 8'b0000_0111);
`else
    check("rate_pattern", vbits, 8'b0001_0101);
`endif
    check("rate_halt", {halted, issue_if.pc}, {1'b1, 4'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
